// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: instruction-fetch port, load/store port, byte-wide
// RAM port and the busy flag. The slave modport is the controller side;
// the master modport is the requester/RAM side.
interface mem_ctrl_if #(
  parameter int MADDR_SZ = 32
);
  // fetch requester
  logic                if_req;
  logic [MADDR_SZ-1:0] if_addr;
  logic [31:0]         if_data;
  logic                if_ack;
  // load/store requester
  logic                ls_req;
  logic                ls_we;
  logic [1:0]          ls_size;
  logic [MADDR_SZ-1:0] ls_addr;
  logic [63:0]         ls_wdata;
  logic [63:0]         ls_rdata;
  logic                ls_ack;
  // byte-wide RAM
  logic [MADDR_SZ-1:0] ram_raddr;
  logic [MADDR_SZ-1:0] ram_waddr;
  logic [7:0]          ram_din;
  logic [7:0]          ram_dout;
  logic                ram_re;
  logic                ram_we;
  // status
  logic                busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, ram_dout,
    output if_data, if_ack, ls_rdata, ls_ack,
    output ram_raddr, ram_waddr, ram_din, ram_re, ram_we, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, ram_dout,
    input  if_data, if_ack, ls_rdata, ls_ack,
    input  ram_raddr, ram_waddr, ram_din, ram_re, ram_we, busy
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and load/store requests onto a byte-wide RAM,
// one byte per ISSUE/CAPTURE pair, little-endian, one transaction at a time.
// Build option: define MEM_CTRL_RR_EN for round-robin arbitration between
// the two requesters; without it load/store has fixed priority over fetch.
module mem_ctrl #(
  parameter int MADDR_SZ = 32
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t              state_reg, state_next;
  logic                sel_ls_reg;    // 1 = current transaction belongs to LS
  logic                we_reg;
  logic [2:0]          last_reg;      // index of the final byte (N-1)
  logic [2:0]          cnt_reg;       // byte index i
  logic [MADDR_SZ-1:0] base_reg;
  logic [63:0]         wdata_reg;
  logic [63:0]         res_reg;       // read bytes gathered so far
  logic [63:0]         res_merged;    // res_reg with the current byte inserted
  logic [31:0]         if_data_reg;
  logic [63:0]         ls_rdata_reg;
  logic [2:0]          ls_last;
  logic                grant_ls, grant_if;
  logic                ram_re_c, ram_we_c, if_ack_c, ls_ack_c;
  logic [7:0]          wbyte [8];

  // little-endian byte lanes of the latched write data
  for (genvar gi = 0; gi < 8; gi++) begin : g_wbyte
    assign wbyte[gi] = wdata_reg[8*gi +: 8];
  end

  // number of bytes minus one for the requested load/store size
  always_comb begin
    ls_last = 3'd0;
    case (bus.ls_size)
      2'd0:    ls_last = 3'd0;
      2'd1:    ls_last = 3'd1;
      2'd2:    ls_last = 3'd3;
      default: ls_last = 3'd7;
    endcase
  end

`ifdef MEM_CTRL_RR_EN
  logic rr_last_ls_reg;  // 1 = LS won the previous grant, 0 = IF did

  // round-robin: a tie goes to whoever was not granted last
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (bus.ls_req && bus.if_req) begin
      grant_ls = !rr_last_ls_reg;
      grant_if = rr_last_ls_reg;
    end else begin
      grant_ls = bus.ls_req;
      grant_if = bus.if_req;
    end
  end

  // remember the last winner; reset leaves it on IF so the first tie goes to LS
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_ls_reg <= 1'b0;
    end else if (state_reg == IDLE && (grant_ls || grant_if)) begin
      rr_last_ls_reg <= grant_ls;
    end
  end
`else
  // fixed priority: load/store beats fetch
  assign grant_ls = bus.ls_req;
  assign grant_if = bus.if_req && !bus.ls_req;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // next-state and strobe/ack decode
  always_comb begin
    state_next = state_reg;
    ram_re_c   = 1'b0;
    ram_we_c   = 1'b0;
    if_ack_c   = 1'b0;
    ls_ack_c   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_ls || grant_if) state_next = ISSUE;
      end
      ISSUE: begin
        ram_re_c   = !we_reg;
        ram_we_c   = we_reg;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = (cnt_reg == last_reg) ? DONE : ISSUE;
      end
      default: begin
        if_ack_c   = !sel_ls_reg;
        ls_ack_c   = sel_ls_reg;
        state_next = IDLE;
      end
    endcase
  end

  // insert the byte returned by the RAM into lane i
  always_comb begin
    res_merged = res_reg;
    res_merged[{cnt_reg, 3'b000} +: 8] = bus.ram_dout;
  end

  // transaction latch, byte counter and read-data assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ls_reg   <= 1'b0;
      we_reg       <= 1'b0;
      last_reg     <= '0;
      cnt_reg      <= '0;
      base_reg     <= '0;
      wdata_reg    <= '0;
      res_reg      <= '0;
      if_data_reg  <= '0;
      ls_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_ls || grant_if) begin
            sel_ls_reg <= grant_ls;
            we_reg     <= grant_ls && bus.ls_we;
            last_reg   <= grant_ls ? ls_last : 3'd3;
            base_reg   <= grant_ls ? bus.ls_addr : bus.if_addr;
            wdata_reg  <= grant_ls ? bus.ls_wdata : '0;
            cnt_reg    <= '0;
            res_reg    <= '0;
          end
        end
        CAPTURE: begin
          if (!we_reg) res_reg <= res_merged;
          if (cnt_reg == last_reg) begin
            // publish only on a completed read so the outputs hold otherwise
            if (!we_reg) begin
              if (sel_ls_reg) ls_rdata_reg <= res_merged;
              else            if_data_reg  <= res_merged[31:0];
            end
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // address wraps naturally at the MADDR_SZ boundary
  assign bus.ram_raddr = base_reg + MADDR_SZ'(cnt_reg);
  assign bus.ram_waddr = base_reg + MADDR_SZ'(cnt_reg);
  assign bus.ram_din   = wbyte[cnt_reg];
  assign bus.ram_re    = ram_re_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.if_ack    = if_ack_c;
  assign bus.ls_ack    = ls_ack_c;
  assign bus.if_data   = if_data_reg;
  assign bus.ls_rdata  = ls_rdata_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a vector table of single transactions plus
// hand-written sequences for arbitration ties and reset mid-store.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.MADDR_SZ(32)) bus ();

  mem_ctrl #(.MADDR_SZ(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int miscompares = 0;

  // byte RAM model: 256 bytes aliased on addr[7:0]; acts on the strobe at the edge
  logic [7:0]  mem [256];
  logic [31:0] rlog [$];
  logic [39:0] wlog [$];

  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_waddr[7:0]] = bus.ram_din;
      wlog.push_back({bus.ram_waddr, bus.ram_din});
    end
    if (bus.ram_re) begin
      bus.ram_dout <= mem[bus.ram_raddr[7:0]];
      rlog.push_back(bus.ram_raddr);
    end
  end

  // strobe legality, sampled mid-cycle
  logic re_q = 1'b0, we_q = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(bus.ram_re && bus.ram_we)) else begin
        $display("FAIL strobe_overlap: re=%0b we=%0b required not both 1", bus.ram_re, bus.ram_we);
        miscompares++;
      end
      assert (!(re_q && bus.ram_re) && !(we_q && bus.ram_we)) else begin
        $display("FAIL strobe_back_to_back: re=%0b/%0b we=%0b/%0b required no consecutive highs",
                 re_q, bus.ram_re, we_q, bus.ram_we);
        miscompares++;
      end
    end
    re_q = bus.ram_re;
    we_q = bus.ram_we;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  typedef struct {
    bit        is_ls;
    bit        we;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [63:0] wdata;
    bit [31:0] exp_if;
    bit [63:0] exp_ls;
    int        exp_lat;
    int        exp_re;
    int        exp_we;
  } vec_t;

  vec_t vt [12];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int mism;
    lat = -1;
    @(negedge clk);
    rlog.delete();
    wlog.delete();
    if (v.is_ls) begin
      bus.ls_we    = v.we;
      bus.ls_size  = v.size;
      bus.ls_addr  = v.addr;
      bus.ls_wdata = v.wdata;
      bus.ls_req   = 1'b1;
    end else begin
      bus.if_addr = v.addr;
      bus.if_req  = 1'b1;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (v.is_ls ? bus.ls_ack : bus.if_ack) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d_if_data", idx), 64'(bus.if_data), 64'(v.exp_if));
    chk($sformatf("v%0d_ls_rdata", idx), bus.ls_rdata, v.exp_ls);
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_ack_busy_after", idx), {61'd0, bus.if_ack, bus.ls_ack, bus.busy}, 64'd0);
    chk($sformatf("v%0d_re_pulses", idx), 64'(rlog.size()), 64'(v.exp_re));
    chk($sformatf("v%0d_we_pulses", idx), 64'(wlog.size()), 64'(v.exp_we));
    mism = 0;
    foreach (rlog[i]) if (rlog[i] !== 32'(v.addr + 32'(i))) mism++;
    foreach (wlog[i]) if (wlog[i] !== {32'(v.addr + 32'(i)), v.wdata[8*i +: 8]}) mism++;
    chk($sformatf("v%0d_ram_sequence", idx), 64'(mism), 64'd0);
  endtask

  logic [1:0] exp_order [4];
  logic [1:0] got_order [4];
  int         got_time  [4];
  int         t_ls, t_if;

  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;

    //          ls  we  sz  addr          wdata                  exp_if        exp_ls                 lat re we
    vt[0]  = '{1'b0, 1'b0, 2'd0, 32'h10,       64'h0,                 32'h12345678, 64'h0,                  9, 4, 0};
    vt[1]  = '{1'b1, 1'b1, 2'd3, 32'h20,       64'h1122334455667788,  32'h12345678, 64'h0,                 17, 0, 8};
    vt[2]  = '{1'b1, 1'b0, 2'd3, 32'h20,       64'h0,                 32'h12345678, 64'h1122334455667788,  17, 8, 0};
    vt[3]  = '{1'b1, 1'b0, 2'd0, 32'h23,       64'h0,                 32'h12345678, 64'h55,                 3, 1, 0};
    vt[4]  = '{1'b1, 1'b0, 2'd1, 32'h21,       64'h0,                 32'h12345678, 64'h6677,               5, 2, 0};
    vt[5]  = '{1'b1, 1'b0, 2'd2, 32'h22,       64'h0,                 32'h12345678, 64'h33445566,           9, 4, 0};
    vt[6]  = '{1'b0, 1'b0, 2'd0, 32'h24,       64'h0,                 32'h11223344, 64'h33445566,           9, 4, 0};
    vt[7]  = '{1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 64'hBEEF,              32'h11223344, 64'h33445566,           5, 0, 2};
    vt[8]  = '{1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 64'h0,                 32'h11223344, 64'hBEEF,               5, 2, 0};
    vt[9]  = '{1'b1, 1'b1, 2'd0, 32'h30,       64'hFFFFFFFFFFFFFFA5,  32'h11223344, 64'hBEEF,               3, 0, 1};
    vt[10] = '{1'b1, 1'b0, 2'd2, 32'h30,       64'h0,                 32'h11223344, 64'hA5,                 9, 4, 0};
    vt[11] = '{1'b0, 1'b0, 2'd0, 32'hFFFFFFFE, 64'h0,                 32'h00BEEF00, 64'hA5,                 9, 4, 0};

`ifdef MEM_CTRL_RR_EN
    exp_order[0] = 2'b10; exp_order[1] = 2'b01; exp_order[2] = 2'b10; exp_order[3] = 2'b01;
`else
    exp_order[0] = 2'b10; exp_order[1] = 2'b10; exp_order[2] = 2'b10; exp_order[3] = 2'b10;
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes_acks_busy", {59'd0, bus.ram_re, bus.ram_we, bus.if_ack, bus.ls_ack, bus.busy}, 64'd0);
    chk("reset_if_data", 64'(bus.if_data), 64'd0);
    chk("reset_ls_rdata", bus.ls_rdata, 64'd0);
    chk("reset_ram_addr_din", {bus.ram_raddr, bus.ram_waddr[23:0], bus.ram_din}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // tie, each requester drops at its own ack: LS first, IF 19 cycles after raise
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    t_ls = -1; t_if = -1;
    bus.if_addr = 32'h10; bus.ls_addr = 32'h10; bus.ls_size = 2'd2; bus.ls_we = 1'b0;
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (bus.ls_ack) t_ls = k;
      if (bus.if_ack) t_if = k;
      @(negedge clk);
      if (t_ls == k) bus.ls_req = 1'b0;
      if (t_if == k) bus.if_req = 1'b0;
      if (t_ls > 0 && t_if > 0) break;
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    chk("tie_ls_ack_cycle", 64'(t_ls), 64'd9);
    chk("tie_if_ack_cycle", 64'(t_if), 64'd19);
    chk("tie_if_data", 64'(bus.if_data), 64'h12345678);
    chk("tie_ls_rdata", bus.ls_rdata, 64'h12345678);

    // both requests held high across four grants
    @(negedge clk);
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      got_order[g] = 2'b00;
      got_time[g]  = -1;
    end
    begin
      int g;
      g = 0;
      for (int k = 1; k <= 80 && g < 4; k++) begin
        @(posedge clk);
        #1;
        if (bus.ls_ack || bus.if_ack) begin
          got_order[g] = {bus.ls_ack, bus.if_ack};
          got_time[g]  = k;
          g++;
        end
      end
    end
    @(negedge clk);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rep_tie_grant%0d_ls_if", g), 64'(got_order[g]), 64'(exp_order[g]));
      chk($sformatf("rep_tie_grant%0d_cycle", g), 64'(got_time[g]), 64'(9 + 10 * g));
    end
    repeat (2) @(posedge clk);

    // reset during CAPTURE of byte 2 of an 8-byte store
    @(negedge clk);
    wlog.delete();
    bus.ls_we = 1'b1; bus.ls_size = 2'd3; bus.ls_addr = 32'h40;
    bus.ls_wdata = 64'h8877665544332211; bus.ls_req = 1'b1;
    t_ls = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.ls_ack || bus.if_ack) t_ls++;
    end
    chk("midrst_writes_issued", 64'(wlog.size()), 64'd3);
    @(negedge clk);
    rst = 1'b1; bus.ls_req = 1'b0;
    @(posedge clk);
    #1;
    if (bus.ls_ack || bus.if_ack) t_ls++;
    chk("midrst_no_ack", 64'(t_ls), 64'd0);
    chk("midrst_idle_next", {62'd0, bus.busy, bus.ram_we}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_bytes01", {48'd0, mem[8'h41], mem[8'h40]}, 64'h2211);
    chk("midrst_bytes3to7", {24'd0, mem[8'h47], mem[8'h46], mem[8'h45], mem[8'h44], mem[8'h43]}, 64'd0);
    begin
      vec_t v;
      v = '{1'b1, 1'b0, 2'd1, 32'h40, 64'h0, 32'h0, 64'h2211, 5, 2, 0};
      run_vec(v, 12);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

  // absolute guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter: MADDR_SZ, 32, byte-address width.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: if_req in 1 fetch request; if_addr in MADDR_SZ start address; if_data out 32 fetched word; if_ack out 1 one-cycle done pulse.
REQ-005 SHALL have ports: ls_req in 1 load/store request; ls_we in 1 1=store; ls_size in 2 (0=1B, 1=2B, 2=4B, 3=8B); ls_addr in MADDR_SZ; ls_wdata in 64; ls_rdata out 64; ls_ack out 1 one-cycle done pulse.
REQ-006 SHALL have ports: ram_raddr out MADDR_SZ; ram_waddr out MADDR_SZ; ram_din out 8 write byte; ram_dout in 8 read byte; ram_re out 1 read strobe; ram_we out 1 write strobe; busy out 1 (high when state is not IDLE).

Function
REQ-007 SHALL sequence the byte-wide, strobe-edge-triggered RAM so that one multi-byte transaction executes at a time.
REQ-008 SHALL implement the states IDLE, ISSUE, CAPTURE and DONE.
REQ-009 IDLE: on a granted request, SHALL latch the requester, address, size, we and wdata, clear the byte counter, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-010 ISSUE: SHALL drive ram_raddr = ram_waddr = base + i (mod 2^MADDR_SZ), drive ram_din = wdata byte i, and drive ram_re = 1 for reads or ram_we = 1 for stores, for exactly one cycle.
REQ-011 CAPTURE: SHALL drive both strobes low; on reads, SHALL store ram_dout into result byte i; if i = N-1, SHALL go to DONE, else SHALL increment i and go to ISSUE.
REQ-012 DONE: SHALL pulse the granted requester's ack for one cycle, with its data output valid in that cycle, then return to IDLE.
REQ-013 Byte order SHALL be little-endian: byte i maps to data bits [8i+7:8i].
REQ-014 Fetches SHALL always be reads of N=4; for loads, N = 1,2,4,8 per ls_size.
REQ-015 Unused upper bytes of ls_rdata SHALL be zero; zero/sign extension belongs to the requester.
REQ-016 Latency SHALL be exactly 2N+1 cycles from the grant edge to ack high (4-byte read: ack 9 cycles after grant).
REQ-017 No alignment SHALL be required; an address wrapping past 2^MADDR_SZ-1 SHALL continue at 0.
REQ-018 Requester rule: req and its inputs SHALL stay stable until ack, and req SHALL be dropped at the edge where ack is sampled high; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-019 ram_re and ram_we SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-020 Requests arriving while busy SHALL wait and SHALL NOT be lost.
REQ-021 if_data and ls_rdata SHALL hold their values until the next completed read by the same requester.

Reset
REQ-022 When rst is high at a clock edge: state SHALL go to IDLE; ram_re, ram_we, if_ack, ls_ack and busy SHALL be 0; if_data, ls_rdata, ram_raddr, ram_waddr and ram_din SHALL be 0; the round-robin pointer SHALL point to IF.
REQ-023 Reset mid-transaction SHALL abandon it with no ack; bytes already written SHALL stay written.

Configuration
REQ-024 Macro MEM_CTRL_RR_EN SHALL select the arbitration scheme.
REQ-025 Without the macro: fixed priority SHALL apply, ls_req over if_req, whenever both are high in IDLE.
REQ-026 With the macro, round-robin SHALL apply: on a tie, the grant SHALL go to the requester not granted last; after reset the first tie SHALL go to LS; a lone request SHALL be granted immediately in both modes.

Verification
REQ-027 Reset -> all outputs 0, busy 0; then if_req at 0x10 with RAM 0x10..0x13 = 78 56 34 12 -> if_data 0x12345678, if_ack exactly 9 cycles after grant, four ram_re pulses.
REQ-028 ls store, size 3, addr 0x20, wdata 0x1122334455667788 -> eight ram_we pulses writing 88,77,...,11 to 0x20..0x27; ls_ack at cycle 17; ram_re never high.
REQ-029 if_req and ls_req raised in the same cycle -> default build: LS served first, IF acked 2N+1+1+9 cycles later; MEM_CTRL_RR_EN build, repeated ties -> grants alternate LS, IF, LS, IF.
REQ-030 ls load, size 1, addr 0xFFFFFFFF -> bytes read from 0xFFFFFFFF then 0x00000000; ls_rdata[63:16] = 0.
REQ-031 rst asserted during the CAPTURE of byte 2 of an 8-byte store -> no ack; bytes 0-1 written; IDLE next cycle; a new request then completes normally.
REQ-032 Every test: an assertion that ram_re and ram_we are never both high and that no strobe is high in two consecutive cycles.
